if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end of the RISC-V pipeline: owns the PC, issues one-outstanding requests to
//  instruction memory and delivers {pc, instr} into the IF/ID stage register. It is the producer side of
//  the stage-register write interface: it honours the hazard unit's stall (register enable low) as
//  backpressure and the EX-stage redirect (taken branch/jump) as a flush. Sits between imem and IF/ID.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INSTR 32'h0000_0013  instruction presented on if_instr when if_valid=0 (addi x0,x0,0)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   asynchronous, active-low reset (rst==0 resets)
//  stall           in   1   hazard unit: IF/ID not loading this cycle; output must hold
//  redirect_valid  in   1   EX stage: discard in-flight work, refetch from redirect_pc
//  redirect_pc     in   32  redirect target (bits[1:0] ignored, forced 0)
//  imem_req        out  1   fetch request; held with imem_addr stable until imem_gnt
//  imem_addr       out  32  fetch address, word aligned
//  imem_gnt        in   1   request accepted this cycle (req&&gnt = handshake)
//  imem_rvalid     in   1   response valid; >=1 cycle after gnt, in order
//  imem_rdata      in   32  instruction word
//  if_valid        out  1   if_pc/if_instr valid for IF/ID; consumed when if_valid && !stall
//  if_pc           out  32  PC of presented instruction
//  if_instr        out  32  presented instruction (NOP_INSTR when !if_valid)
// BEHAVIOUR
//  Reset: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP_INSTR,
//   skid empty, kill=0, state=IDLE. After rst deasserts: one IDLE cycle, then REQ.
//  States: IDLE -> REQ. REQ: imem_req=1, imem_addr=pc; on gnt -> WAIT. WAIT: on rvalid -> REQ if skid
//   will be empty next cycle, else BLOCK. BLOCK: imem_req=0; -> REQ the cycle after skid drains.
//  At most one request outstanding; response-to-output latency 1 cycle (rdata registered into if_*).
//  Storage: output register + one-entry skid buffer. Accepted response (not killed) loads output if
//   output empty or consumed this cycle, else loads skid. Consume with skid full: skid -> output.
//  pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) on each gnt; imem_addr follows pc while in REQ.
//  Redirect (highest priority, ignores stall): next cycle if_valid=0, skid emptied, pc=redirect_pc&~3,
//   state=REQ. If a request is granted but unanswered (WAIT, or gnt in the same cycle), set kill; the
//   matching rvalid is dropped, kill clears, no output update. A REQ without gnt is retargeted (addr
//   may change, allowed only on redirect).
//  Redirect and rvalid in same cycle: response dropped. Redirect and gnt in same cycle: kill set.
//  Stall while if_valid: if_pc/if_instr/if_valid held bit-stable; fetching continues into skid.
//  Async reset mid-transaction: state cleared immediately; late imem_rvalid after reset with no
//   request outstanding is ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra outputs perf_fetched[31:0] (count of consumed instructions) and
//   perf_stall[31:0] (cycles with if_valid && stall); both reset to 0, wrap at 2^32, cleared by rst only.
//  FETCH_PERF_EN undefined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  Shared package/header (riscv_pkg): RESET_PC default, NOP_INSTR, fetch FSM state encoding
//   (IDLE, REQ, WAIT, BLOCK, 2 bits).
//  One natural sub-module: fetch_skid_buf (1-entry {pc,instr} buffer, load/unload/flush); rest flat.
// TESTING
//  1 Reset release, imem gnt same cycle, rvalid next -> addrs 0,4,8 back-to-back; if_pc 0,4,8 each with its rdata.
//  2 stall=1 for 5 cycles while if_valid -> output frozen, skid fills, imem_req drops (BLOCK); release -> no loss/dup.
//  3 redirect_valid with redirect_pc=32'h0000_0103 in WAIT -> stale rvalid dropped, next imem_addr=32'h100, if_valid=0 one cycle.
//  4 redirect in same cycle as rvalid and as stall=1 -> if_valid=0 next cycle, that response never presented.
//  5 RESET_PC=32'hFFFF_FFF8 -> fetch addrs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  6 FETCH_PERF_EN: 10 consumed, 3 stalled cycles -> perf_fetched=10, perf_stall=3; rst low mid-run -> both 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end: reset defaults,
// the fetch FSM state encoding and the {pc, instr} entry type.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    BLOCK = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} skid buffer behind the IF output register.
// Flush beats load, load beats unload.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  fetch_entry_t data_i,
  output logic         valid_o,
  output fetch_entry_t data_o
);

  logic         valid_q;
  fetch_entry_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too so the output mux never sees X; a deep
      // buffer array would normally leave its storage unreset.
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RISC-V instruction-fetch front end: PC, one-outstanding imem requests, output
// register plus skid buffer toward IF/ID. Define FETCH_PERF_EN for perf counters.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;
  logic         req_q, req_d;
  logic         out_valid_q, out_valid_d;
  fetch_entry_t out_q, out_d;

  logic         skid_valid, skid_load, skid_unload, skid_next;
  fetch_entry_t skid_data, rsp_entry;
  logic         gnt_fire, consume, accept;

  assign gnt_fire  = req_q && imem_gnt;
  assign consume   = out_valid_q && !stall;
  // A response is only ours in WAIT and only if no redirect killed it.
  assign accept    = (state_q == WAIT) && imem_rvalid && !kill_q && !redirect_valid;
  assign rsp_entry = '{pc: req_pc_q, instr: imem_rdata};

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    out_valid_d = out_valid_q;
    out_d       = out_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (consume && skid_valid) begin
      out_valid_d = 1'b1;
      out_d       = skid_data;
      skid_unload = 1'b1;
      skid_load   = accept;
    end else if (accept && (!out_valid_q || consume)) begin
      out_valid_d = 1'b1;
      out_d       = rsp_entry;
    end else if (accept) begin
      skid_load = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  assign skid_next = !redirect_valid && (skid_load || (skid_valid && !skid_unload));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q && !imem_rvalid;
    if (gnt_fire) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (gnt_fire) state_d = WAIT;
      WAIT:    if (imem_rvalid) state_d = skid_next ? BLOCK : REQ;
      BLOCK:   if (!skid_next) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      state_d = REQ;
      pc_d    = align_word(redirect_pc);
      // A granted-but-unanswered request must have its response swallowed.
      kill_d  = gnt_fire || (state_q == WAIT && !imem_rvalid) || (kill_q && !imem_rvalid);
    end
    // No new request while a killed response is still due: keeps one outstanding.
    req_d = (state_d == REQ) && !kill_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      kill_q      <= 1'b0;
      req_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '{pc: 32'd0, instr: NOP_INSTR};
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      req_q       <= req_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst),
    .flush_i  (redirect_valid),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (rsp_entry),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = out_valid_q;
  assign if_pc     = out_q.pc;
  assign if_instr  = out_valid_q ? out_q.instr : NOP_INSTR;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (consume)              perf_fetched_q <= perf_fetched_q + 32'd1;
      if (out_valid_q && stall) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed cycle table, wrap instance,
// randomized run against a sequential-PC reference model, async reset, perf.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, redirect_valid, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;

  logic        stall_w, redirect_valid_w, imem_gnt_w, imem_rvalid_w;
  logic [31:0] redirect_pc_w, imem_rdata_w;
  logic        imem_req_w, if_valid_w;
  logic [31:0] imem_addr_w, if_pc_w, if_instr_w;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_fetched_w, perf_stall_w;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(stall_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(imem_gnt_w),
    .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched_w), .perf_stall(perf_stall_w),
`endif
    .if_valid(if_valid_w), .if_pc(if_pc_w), .if_instr(if_instr_w)
  );

  typedef struct {
    logic        st, rd;
    logic [31:0] rpc;
    logic        g, rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int st, input int rd, input logic [31:0] rpc,
                              input int g, input int rv, input int ereq,
                              input logic [31:0] eaddr, input int ev, input logic [31:0] epc);
    vec_t v;
    v.st = (st != 0);  v.rd = (rd != 0);  v.rpc = rpc;
    v.g  = (g != 0);   v.rv = (rv != 0);
    v.e_req = (ereq != 0); v.e_addr = eaddr; v.e_val = (ev != 0); v.e_pc = epc;
    return v;
  endfunction

  // Contents of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = '0;
    imem_gnt_w = 1'b0; imem_rvalid_w = 1'b0; imem_rdata_w = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    zero_inputs();
    repeat (2) tick();
    check("reset req",       32'(imem_req), 32'd0);
    check("reset addr",      imem_addr, 32'd0);
    check("reset valid",     32'(if_valid), 32'd0);
    check("reset if_pc",     if_pc, 32'd0);
    check("reset if_instr",  if_instr, NOP);
    check("reset wrap req",  32'(imem_req_w), 32'd0);
    check("reset wrap addr", imem_addr_w, 32'hFFFF_FFF8);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hs, pend, cons, pv, pstall, preq, pgnt, predir;
    logic [31:0] hs_addr, pend_addr, gnt_addr, exp_pc, ppc, pin, paddr;
    logic [31:0] addrs_q[$], pcs_q[$];
    logic [31:0] wrap_exp[3];
    int          lat, n_cons;

    zero_inputs();
    do_reset();

    // Wrap instance: continuous grant, single-cycle response latency.
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
    pend = 1'b0; pend_addr = '0;
    for (int c = 0; c < 40 && pcs_q.size() < 3; c++) begin
      imem_gnt_w = 1'b1; imem_rvalid_w = pend; imem_rdata_w = mem_word(pend_addr);
      hs = imem_req_w; hs_addr = imem_addr_w;
      if (hs) addrs_q.push_back(imem_addr_w);
      if (if_valid_w) begin
        pcs_q.push_back(if_pc_w);
        check("wrap instr", if_instr_w, mem_word(if_pc_w));
      end
      tick();
      if (imem_rvalid_w) pend = 1'b0;
      if (hs) begin pend = 1'b1; pend_addr = hs_addr; end
    end
    imem_gnt_w = 1'b0; imem_rvalid_w = 1'b0;
    check("wrap pc count", 32'(pcs_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < addrs_q.size()) check($sformatf("wrap addr%0d", i), addrs_q[i], wrap_exp[i]);
      if (i < pcs_q.size())   check($sformatf("wrap pc%0d", i), pcs_q[i], wrap_exp[i]);
    end

    do_reset();

    // Directed cycle table: inputs before the edge, expected outputs after it.
    vq.push_back(mk(0,0,0,        0,0, 1,32'h000, 0,0));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h004, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h004, 1,32'h000));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h008, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h008, 1,32'h004));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h00C, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h00C, 1,32'h008));
    vq.push_back(mk(1,0,0,        1,0, 0,32'h010, 1,32'h008));
    vq.push_back(mk(1,0,0,        0,1, 0,32'h010, 1,32'h008));
    vq.push_back(mk(1,0,0,        0,0, 0,32'h010, 1,32'h008));
    vq.push_back(mk(1,0,0,        0,0, 0,32'h010, 1,32'h008));
    vq.push_back(mk(1,0,0,        0,0, 0,32'h010, 1,32'h008));
    vq.push_back(mk(0,0,0,        0,0, 1,32'h010, 1,32'h00C));
    vq.push_back(mk(0,0,0,        0,0, 1,32'h010, 0,0));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h014, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h014, 1,32'h010));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h018, 0,0));
    vq.push_back(mk(0,1,32'h103,  0,0, 0,32'h100, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h100, 0,0));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h104, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h104, 1,32'h100));
    vq.push_back(mk(1,0,0,        1,0, 0,32'h108, 1,32'h100));
    vq.push_back(mk(1,1,32'h200,  0,1, 1,32'h200, 0,0));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h204, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h204, 1,32'h200));
    vq.push_back(mk(0,1,32'h300,  1,0, 0,32'h300, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h300, 0,0));
    vq.push_back(mk(0,0,0,        1,0, 0,32'h304, 0,0));
    vq.push_back(mk(0,0,0,        0,1, 1,32'h304, 1,32'h300));

    gnt_addr = '0;
    foreach (vq[i]) begin
      stall = vq[i].st; redirect_valid = vq[i].rd; redirect_pc = vq[i].rpc;
      imem_gnt = vq[i].g; imem_rvalid = vq[i].rv; imem_rdata = mem_word(gnt_addr);
      hs = imem_req && imem_gnt; hs_addr = imem_addr;
      tick();
      if (hs) gnt_addr = hs_addr;
      check($sformatf("vec%0d req", i),   32'(imem_req), 32'(vq[i].e_req));
      check($sformatf("vec%0d addr", i),  imem_addr, vq[i].e_addr);
      check($sformatf("vec%0d valid", i), 32'(if_valid), 32'(vq[i].e_val));
      if (vq[i].e_val) begin
        check($sformatf("vec%0d pc", i),    if_pc, vq[i].e_pc);
        check($sformatf("vec%0d instr", i), if_instr, mem_word(vq[i].e_pc));
      end else begin
        check($sformatf("vec%0d nop", i),   if_instr, NOP);
      end
    end

    // Randomized run: consumed PCs must follow pc+4 from the last redirect.
    exp_pc = 32'h300; pend = 1'b0; pend_addr = '0; lat = 0; n_cons = 0;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = (c == 0) || ($urandom_range(0, 31) == 0);
      redirect_pc    = $urandom();
      imem_gnt       = ($urandom_range(0, 3) != 0);
      imem_rvalid    = pend && (lat == 0);
      imem_rdata     = imem_rvalid ? mem_word(pend_addr) : $urandom();
      hs = imem_req && imem_gnt; hs_addr = imem_addr;
      cons = if_valid && !stall;
      if (hs) check("rand one outstanding", 32'(pend), 32'd0);
      if (if_valid) check("rand instr", if_instr, mem_word(if_pc));
      else          check("rand nop", if_instr, NOP);
      if (cons) check("rand pc order", if_pc, exp_pc);
      pv = if_valid; ppc = if_pc; pin = if_instr; pstall = stall;
      preq = imem_req; pgnt = imem_gnt; paddr = imem_addr; predir = redirect_valid;
      tick();
      if (cons) begin exp_pc = exp_pc + 32'd4; n_cons++; end
      if (predir) exp_pc = redirect_pc & ~32'd3;
      if (imem_rvalid) pend = 1'b0;
      else if (pend && lat > 0) lat--;
      if (hs) begin pend = 1'b1; pend_addr = hs_addr; lat = int'($urandom_range(0, 2)); end
      if (predir) begin
        check("rand flush valid", 32'(if_valid), 32'd0);
      end else begin
        if (pv && pstall) begin
          check("rand hold valid", 32'(if_valid), 32'd1);
          check("rand hold pc", if_pc, ppc);
          check("rand hold instr", if_instr, pin);
        end
        if (preq && !pgnt) begin
          check("rand req held", 32'(imem_req), 32'd1);
          check("rand addr held", imem_addr, paddr);
        end
      end
    end
    check("rand progress", 32'(n_cons > 200), 32'd1);
    zero_inputs();

    // Asynchronous reset mid-run, then late responses with nothing outstanding.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async rst req", 32'(imem_req), 32'd0);
    check("async rst valid", 32'(if_valid), 32'd0);
    check("async rst addr", imem_addr, 32'd0);
    check("async rst instr", if_instr, NOP);
    repeat (2) tick();
    rst = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("late rvalid idle valid", 32'(if_valid), 32'd0);
    check("late rvalid idle req", 32'(imem_req), 32'd1);
    tick();
    check("late rvalid req valid", 32'(if_valid), 32'd0);
    imem_rvalid = 1'b0;

`ifdef FETCH_PERF_EN
    begin
      int nf, ns;
      check("perf fetched reset", perf_fetched, 32'd0);
      check("perf stall reset", perf_stall, 32'd0);
      nf = 0; ns = 0; pend = 1'b0; pend_addr = '0;
      for (int c = 0; c < 200 && nf < 10; c++) begin
        stall = if_valid && (ns < 3) && (nf >= 2);
        imem_gnt = 1'b1; imem_rvalid = pend; imem_rdata = mem_word(pend_addr);
        hs = imem_req && imem_gnt; hs_addr = imem_addr;
        if (if_valid && !stall) nf++;
        if (if_valid && stall) ns++;
        tick();
        if (imem_rvalid) pend = 1'b0;
        if (hs) begin pend = 1'b1; pend_addr = hs_addr; end
      end
      stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      check("perf run consumed", 32'(nf), 32'd10);
      check("perf fetched", perf_fetched, 32'd10);
      check("perf stall", perf_stall, 32'd3);
      rst = 1'b0;
      #1;
      check("perf fetched clear", perf_fetched, 32'd0);
      check("perf stall clear", perf_stall, 32'd0);
      tick();
      rst = 1'b1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
